// File: rtl/mux10_rr_arbiter_if.sv
// Bus between the round-robin arbiter, its ten requesters, the external mux10 and the consumer.
interface mux10_rr_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int N_REQ  = 10
);
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  gnt;
  logic [3:0]        sel;
  logic [DATA_W-1:0] mux_y;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  modport master (
    input  req, mux_y, out_ready,
    output gnt, sel, out_data, out_valid, busy
  );

  modport slave (
    output req, mux_y, out_ready,
    input  gnt, sel, out_data, out_valid, busy
  );
endinterface

// File: rtl/mux10_rr_arbiter.sv
// Round-robin arbiter steering an external mux10 and capturing its output into a one-word register.
// Request to out_valid is 2 cycles; out_valid/out_data hold while out_ready is low, new arbitration only after acceptance.
module mux10_rr_arbiter #(
  parameter int DATA_W = 16,
  parameter int N_REQ  = 10
) (
  input  logic               clk,
  input  logic               rst,
  mux10_rr_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  localparam logic [3:0]       LAST = 4'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t     state;
  logic [3:0] ptr;
  logic       win_found;
  logic [3:0] win_idx;

  // Rotating priority search: ptr has highest priority, wrapping past LAST back to 0.
  always_comb begin
    int         cand;
    logic [3:0] cidx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cidx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cidx = 4'(cand);
      if (!win_found && bus.req[cidx]) begin
        win_found = 1'b1;
        win_idx   = cidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.gnt       <= '0;
      bus.sel       <= '0;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.gnt <= '0;
          if (win_found) begin
            bus.gnt  <= ONE << win_idx;
            bus.sel  <= win_idx;
            ptr      <= (win_idx == LAST) ? 4'd0 : win_idx + 4'd1;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          // sel has been stable for a full cycle, so mux_y reflects the granted input.
          bus.out_data  <= bus.mux_y;
          bus.out_valid <= 1'b1;
          state         <= SEND;
        end
        SEND: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.gnt       <= '0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.gnt       <= '0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux10_rr_arbiter.sv
// Directed bench for mux10_rr_arbiter with a behavioural mux10 driven from sel.
module tb_mux10_rr_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [15:0] d_tbl [10] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E,
                              16'h000F, 16'h0001, 16'h0002, 16'h0003, 16'h0004};

  mux10_rr_arbiter_if #(.DATA_W(16), .N_REQ(10)) bus ();

  mux10_rr_arbiter #(.DATA_W(16), .N_REQ(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.mux_y = (bus.sel < 4'd10) ? d_tbl[bus.sel] : 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] req;
    int         win;
    int         stall;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (bus.sel > 4'd9) begin
      errors++;
      $display("FAIL sel_range: got %0d expected <= 9 at %0t", bus.sel, $time);
    end
  endtask

  task automatic run_txn(input logic [9:0] r, input int w, input int stall);
    logic [15:0] exp_d;
    logic [9:0]  exp_g;
    logic [9:0]  one10;
    one10 = 10'b1;
    exp_d = d_tbl[w];
    exp_g = one10 << w;
    bus.req       = r;
    bus.out_ready = (stall == 0);
    tick();
    check("grant_gnt",  32'(bus.gnt), 32'(exp_g));
    check("grant_sel",  32'(bus.sel), 32'(w));
    check("grant_busy", 32'(bus.busy), 32'd1);
    check("grant_nval", 32'(bus.out_valid), 32'd0);
    bus.req = '0;
    tick();
    check("load_valid", 32'(bus.out_valid), 32'd1);
    check("load_data",  32'(bus.out_data), 32'(exp_d));
    check("load_gnt",   32'(bus.gnt), 32'(exp_g));
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_data",  32'(bus.out_data), 32'(exp_d));
      check("stall_gnt",   32'(bus.gnt), 32'(exp_g));
    end
    bus.out_ready = 1'b1;
    tick();
    check("done_valid", 32'(bus.out_valid), 32'd0);
    check("done_gnt",   32'(bus.gnt), 32'd0);
    check("done_busy",  32'(bus.busy), 32'd0);
    check("done_sel",   32'(bus.sel), 32'(w));
  endtask

  initial begin
    logic [9:0] one10;
    int         w;
    one10  = 10'b1;
    checks = 0;
    errors = 0;

    // Expected winners worked out by hand from the pointer carried between rows.
    vecs[0] = '{10'b0000001000, 3, 0};  // ptr 0 -> 3
    vecs[1] = '{10'b0000100000, 5, 0};  // ptr 4 -> 5, req dropped in LOAD
    vecs[2] = '{10'b0000100001, 0, 0};  // ptr 6 -> wraps to 0
    vecs[3] = '{10'b1000000001, 9, 0};  // ptr 1 -> 9
    vecs[4] = '{10'b1000000001, 0, 0};  // ptr 0 -> 0
    vecs[5] = '{10'b1000000001, 9, 0};  // ptr 1 -> 9
    vecs[6] = '{10'b0010000000, 7, 5};  // ptr 0 -> 7, five stall cycles
    vecs[7] = '{10'h3FF,        8, 0};  // ptr 8 -> 8
    vecs[8] = '{10'h3FF,        9, 0};  // ptr 9 -> 9, ptr back to 0

    rst           = 1'b1;
    bus.req       = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check("rst_gnt",   32'(bus.gnt), 32'd0);
    check("rst_sel",   32'(bus.sel), 32'd0);
    check("rst_data",  32'(bus.out_data), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",  32'(bus.busy), 32'd0);

    rst           = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("idle_gnt",   32'(bus.gnt), 32'd0);
    check("idle_busy",  32'(bus.busy), 32'd0);
    check("idle_valid", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 9; i++) run_txn(vecs[i].req, vecs[i].win, vecs[i].stall);

    // All requesters held with out_ready high: one grant every three cycles, index order, then wrap.
    bus.req       = 10'h3FF;
    bus.out_ready = 1'b1;
    for (int g = 0; g < 11; g++) begin
      w = g % 10;
      tick();
      check("rr_gnt", 32'(bus.gnt), 32'(one10 << w));
      check("rr_sel", 32'(bus.sel), 32'(w));
      tick();
      check("rr_valid", 32'(bus.out_valid), 32'd1);
      check("rr_data",  32'(bus.out_data), 32'(d_tbl[w]));
      tick();
      check("rr_gap", 32'(bus.out_valid), 32'd0);
    end
    bus.req = '0;

    // Reset while in LOAD: transaction dropped, pointer cleared (ptr would otherwise be 5).
    bus.req = 10'b0000010000;
    tick();
    check("rl_gnt", 32'(bus.gnt), 32'(10'b0000010000));
    bus.req = '0;
    rst     = 1'b1;
    tick();
    check("rl_gnt0",   32'(bus.gnt), 32'd0);
    check("rl_sel0",   32'(bus.sel), 32'd0);
    check("rl_valid0", 32'(bus.out_valid), 32'd0);
    check("rl_data0",  32'(bus.out_data), 32'd0);
    check("rl_busy0",  32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();
    check("rl_novalid", 32'(bus.out_valid), 32'd0);
    run_txn(10'b0000100001, 0, 0);

    // Reset while in SEND with a stalled consumer.
    bus.req       = 10'b0000000100;
    bus.out_ready = 1'b0;
    tick();
    bus.req = '0;
    tick();
    check("rs_valid", 32'(bus.out_valid), 32'd1);
    check("rs_data",  32'(bus.out_data), 32'h000C);
    rst = 1'b1;
    tick();
    check("rs_valid0", 32'(bus.out_valid), 32'd0);
    check("rs_data0",  32'(bus.out_data), 32'd0);
    check("rs_gnt0",   32'(bus.gnt), 32'd0);
    rst = 1'b0;
    tick();
    check("rs_novalid", 32'(bus.out_valid), 32'd0);
    check("rs_idle",    32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
